// File: rtl/router_pkg.sv
// Shared constants and helpers for the router input FIFO slice.
package router_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_PTR_W = clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;

endpackage

// File: rtl/router_in_fifo_if.sv
// Push/pop bus between a traffic source / router controller (master) and the FIFO (slave).
interface router_in_fifo_if
    import router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             almost_full;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, data_in, pop,
        input  full, almost_full, data_out, empty, count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop,
        output full, almost_full, data_out, empty, count, overflow, underflow
    );

endinterface

// File: rtl/router_fifo_ram.sv
// DEPTH x WIDTH storage: one write port, one read port with a registered output.
module router_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // occupancy tracking guarantees no unwritten entry is ever read.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // NOTE: non-blocking reads see the pre-edge contents, so a simultaneous
    // write to the same slot (full FIFO, push+pop) still returns the oldest word.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/router_in_fifo.sv
// Single-clock input FIFO for one router client slot; data_out is valid one clock after pop.
module router_in_fifo
    import router_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic            clk,
    input  logic            reset,
    router_in_fifo_if.slave bus
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [WIDTH-1:0] w_rdata;

    // Flags come from the registered count only, never from push/pop.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = bus.push && (!w_full || bus.pop);
    assign w_pop_ok  = bus.pop && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;

            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;

            if (bus.push && w_full && !bus.pop) r_overflow  <= 1'b1;
            if (bus.pop && w_empty)             r_underflow <= 1'b1;
        end
    end

    router_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_push_ok && !reset),
        .waddr (r_wp),
        .wdata (bus.data_in),
        .re    (w_pop_ok),
        .raddr (r_rp),
        .rdata (w_rdata)
    );

    assign bus.data_out    = w_rdata;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (r_count >= AFULL_CNT);
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_router_in_fifo.sv
// Randomised bench for router_in_fifo against a queue-based reference model.
module tb_router_in_fifo;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = DEPTH - 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    router_in_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    router_in_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf;
    bit               m_unf;

    logic [WIDTH-1:0] fill_w [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue semantics of one clock edge, straight from the FIFO's behavioural rules.
    function automatic void model_edge(bit rst, bit p, logic [WIDTH-1:0] d, bit q);
        bit full, empty;
        if (rst) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        if (q && empty)        m_unf = 1'b1;
        if (p && full && !q)   m_ovf = 1'b1;
        if (q && !empty)       m_dout = m_q.pop_front();
        if (p && (!full || q)) m_q.push_back(d);
    endfunction

    task automatic step(input bit rst, input bit p, input logic [WIDTH-1:0] d, input bit q);
        reset        = rst;
        bus.push     = p;
        bus.data_in  = d;
        bus.pop      = q;
        @(posedge clk);
        model_edge(rst, p, d, q);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("count",       64'(bus.count),       64'(m_q.size()));
            check("empty",       64'(bus.empty),       64'(m_q.size() == 0));
            check("full",        64'(bus.full),        64'(m_q.size() == DEPTH));
            check("almost_full", 64'(bus.almost_full), 64'(m_q.size() >= AFULL_LVL));
            check("data_out",    64'(bus.data_out),    64'(m_dout));
            check("overflow",    64'(bus.overflow),    64'(m_ovf));
            check("underflow",   64'(bus.underflow),   64'(m_unf));
        end
    end

    initial begin
        logic [WIDTH-1:0] d;

        step(1'b1, 1'b0, '0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0);
        check("rst_count",    64'(bus.count),    64'd0);
        check("rst_empty",    64'(bus.empty),    64'd1);
        check("rst_data_out", 64'(bus.data_out), 64'd0);

        // Three words in, three out, one clock of pop-to-data latency each.
        step(1'b0, 1'b1, 32'hA0, 1'b0);
        step(1'b0, 1'b1, 32'hA1, 1'b0);
        step(1'b0, 1'b1, 32'hA2, 1'b0);
        check("abc_count", 64'(bus.count), 64'd3);
        check("abc_empty", 64'(bus.empty), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("pop0_data", 64'(bus.data_out), 64'hA0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("pop1_data", 64'(bus.data_out), 64'hA1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("pop2_data",  64'(bus.data_out), 64'hA2);
        check("pop2_empty", 64'(bus.empty),    64'd1);

        // Fill to DEPTH, watching almost_full switch on at AFULL_LVL.
        for (int i = 0; i < DEPTH; i++) begin
            fill_w[i] = $urandom;
            step(1'b0, 1'b1, fill_w[i], 1'b0);
            if (i == AFULL_LVL - 2) check("afull_below", 64'(bus.almost_full), 64'd0);
            if (i == AFULL_LVL - 1) check("afull_at",    64'(bus.almost_full), 64'd1);
        end
        check("fill_full",  64'(bus.full),  64'd1);
        check("fill_count", 64'(bus.count), 64'd16);

        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("ovf_flag",  64'(bus.overflow), 64'd1);
        check("ovf_count", 64'(bus.count),    64'd16);

        // Push and pop together while full: oldest word out, new word into the freed slot.
        step(1'b0, 1'b1, 32'h55, 1'b1);
        check("fullpp_count", 64'(bus.count),    64'd16);
        check("fullpp_data",  64'(bus.data_out), 64'(fill_w[0]));

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("drain_last",  64'(bus.data_out), 64'h55);
        check("drain_empty", 64'(bus.empty),    64'd1);

        step(1'b0, 1'b0, '0, 1'b1);
        check("unf_flag", 64'(bus.underflow), 64'd1);
        check("unf_data", 64'(bus.data_out),  64'h55);

        step(1'b0, 1'b1, 32'h77, 1'b1);
        check("emptypp_count", 64'(bus.count),    64'd1);
        check("emptypp_data",  64'(bus.data_out), 64'h55);

        // Sustained push+pop every cycle with 5 entries resident; pointers wrap twice.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, $urandom, 1'b1);
        check("stream_count", 64'(bus.count), 64'd5);

        // Reset mid-operation with 9 entries and a sticky flag set.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("pre_rst_count", 64'(bus.count),    64'd9);
        check("pre_rst_data",  64'(bus.data_out), 64'h100);
        step(1'b1, 1'b1, 32'h999, 1'b1);
        check("mid_rst_count", 64'(bus.count),     64'd0);
        check("mid_rst_empty", 64'(bus.empty),     64'd1);
        check("mid_rst_unf",   64'(bus.underflow), 64'd0);
        check("mid_rst_data",  64'(bus.data_out),  64'd0);

        // Random traffic with occasional reset; the compare process checks each cycle.
        for (int i = 0; i < 600; i++) begin
            d = $urandom;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 99) < 60,
                 d,
                 $urandom_range(0, 99) < 50);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_in_fifo.md
# router_in_fifo

Synchronous single-clock input FIFO feeding one client slot of the router controller. A traffic source pushes words in; the router controller sees `empty`, issues `pop` on grant, and samples `data_out` exactly one clock later, matching the controller's `DELAY=1` configuration. One instance is placed per client, and the instances' `data_out` buses are concatenated onto the controller's `data_in`.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `AFULL_LVL`, DEPTH-2: `almost_full` asserts when `count` ≥ this value.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request from the source.
- `data_in`  in  WIDTH  write data, sampled with `push`.
- `full`  out  1  no free entry.
- `almost_full`  out  1  `count` ≥ `AFULL_LVL`.
- `pop`  in  1  read request from the router controller.
- `data_out`  out  WIDTH  read data, registered; valid the cycle after an accepted pop.
- `empty`  out  1  no stored entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set by push while full without pop.
- `underflow`  out  1  sticky; set by pop while empty.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits; pointers wrap modulo DEPTH naturally.
- Occupancy is held in the `count` register; `full` = (`count`==DEPTH), `empty` = (`count`==0). Both flags are derived from the registered `count` only and have no combinational path from `push`/`pop`.
- Accepted push: `push && (!full || pop)`. Writes `mem[wp]`, `wp`+1.
- Accepted pop: `pop && !empty`. Loads `data_out` ← `mem[rp]`, `rp`+1.
- `count` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push while full, no pop: data dropped, pointers and count unchanged, `overflow` ← 1.
- Push and pop while full: both accepted; the read returns the oldest entry and the write goes into the freed slot.
- Pop while empty: ignored, `data_out` holds, `underflow` ← 1. Push in the same cycle is still accepted, with no bypass to `data_out`.
- `data_out` changes only on an accepted pop; otherwise it holds its last value.
- `overflow`/`underflow` are cleared only by `reset`.

## Timing
- Reset values: `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0 (if `AFULL_LVL`>0), `data_out`=0, `overflow`=`underflow`=0. Array contents are not reset.
- Reset asserted mid-operation discards all entries on that edge. `push`/`pop` in the reset cycle have no effect.
- Write-to-read latency: word pushed at edge N → `empty`=0 after edge N → earliest pop sampled at edge N+1 → `data_out` valid after edge N+1.
- Pop-to-data latency: exactly 1 clock. `data_out` is stable for the whole following cycle.
- Flags update on the same edge as `count`. Popping the last entry at edge N gives `empty`=1 after edge N, so the controller never pops a stale word.
- Sustained throughput: one push and one pop per clock at any occupancy.

## Structure
- Shared package `router_pkg`:
  - default `WIDTH`;
  - function `clog2` / pointer-width constant;
  - localparam for `count` width.
- One sub-module, `router_fifo_ram`: DEPTH×WIDTH storage with one write port (`we`, `waddr`, `wdata`) and one read port with a registered output (`re`, `raddr`, `rdata`). `rdata` resets to 0 and holds when `re`=0.
- Pointers, `count`, flags and sticky errors live in `router_in_fifo`.

## Test plan
- Reset, then 3 pushes of 0xA0, 0xA1, 0xA2 → `count`=3, `empty`=0. Pops on the next 3 cycles → `data_out` = 0xA0, 0xA1, 0xA2, each one cycle after its pop; `empty`=1 after the third pop.
- Fill with DEPTH=16 pushes → `full`=1, `count`=16, `almost_full` from `count`=14. A 17th push alone → dropped, `overflow`=1; drain returns all 16 words in order.
- While full, push 0x55 and pop together → `count` stays 16, `data_out` = oldest word; 0x55 emerges last after a full drain.
- Pop while empty → `underflow`=1, `data_out` unchanged. Pop+push on empty → push accepted, `count`=1, `data_out` unchanged.
- Push/pop every cycle for 40 cycles with random data → output order matches input, pointers wrap at least twice, `count` is constant.
- Reset asserted with `count`=9 → next cycle `count`=0, `empty`=1, sticky flags 0, `data_out`=0.
